// File: rtl/spi_reg_bridge_if.sv
// Byte-level link between SPI_Slave (master side) and spi_reg_bridge (slave side).
// Handshake: rx_valid and tx_valid are single-cycle pulses with no ready/backpressure;
// rx_data is only meaningful in a cycle where rx_valid=1, tx_data holds until the next tx_valid.
interface spi_reg_bridge_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       spi_busy;
  logic [7:0] tx_data;
  logic       tx_valid;

  modport master (output rx_data, rx_valid, spi_busy, input tx_data, tx_valid);
  modport slave  (input rx_data, rx_valid, spi_busy, output tx_data, tx_valid);
endinterface

// File: rtl/spi_reg_bridge.sv
// Command/data parser for SPI_Slave bytes, backed by a bank of 8-bit registers.
// First byte of a frame: bit7 = write, bits[6:0] = start address; pointer auto-increments.
module spi_reg_bridge #(
  parameter int          NUM_REGS    = 16,
  parameter logic [7:0]  STATUS_BYTE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_cs,
  spi_reg_bridge_if.slave       bus,
  output logic [8*NUM_REGS-1:0] regs,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr,
  output logic                  frame_active,
  output logic [1:0]            state_dbg,
  output logic [6:0]            ptr_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, WRITE = 2'd2, READ = 2'd3} state_t;

  state_t     state_q, state_nx;
  logic [6:0] ptr_q, ptr_rx, ptr_nx;
  logic       cs_meta, cs_s, cs_prev, busy_prev;
  logic [7:0] reg_q [NUM_REGS];
  logic       cs_rise, cs_fall, byte_start, wr_en;
  logic [7:0] rd_val, tx_nx;

  // rx is resolved first (ptr_rx/state_nx); the tx reply is then taken from that post-rx view.
  always_comb begin
    cs_rise    = cs_s & ~cs_prev;
    cs_fall    = ~cs_s & cs_prev;
    byte_start = bus.spi_busy & ~busy_prev;
    state_nx   = state_q;
    ptr_rx     = ptr_q;
    wr_en      = 1'b0;
    if (cs_rise) begin
      state_nx = IDLE;
    end else if (cs_fall) begin
      state_nx = CMD;
    end else if (bus.rx_valid) begin
      case (state_q)
        CMD: begin
          ptr_rx   = bus.rx_data[6:0];
          state_nx = bus.rx_data[7] ? WRITE : READ;
        end
        WRITE: begin
          wr_en  = (32'(ptr_q) < 32'(NUM_REGS));
          ptr_rx = ptr_q + 7'd1;
        end
        default: ;
      endcase
    end

    rd_val = 8'h00;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (7'(k) == ptr_rx) rd_val = reg_q[k];
    end
    if (wr_en && (ptr_q == ptr_rx)) rd_val = bus.rx_data;

    ptr_nx = ptr_rx;
    case (state_nx)
      WRITE:   tx_nx = 8'h00;
      READ:    tx_nx = rd_val;
      default: tx_nx = STATUS_BYTE;
    endcase
    if (byte_start && (state_nx == READ)) ptr_nx = ptr_rx + 7'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_meta      <= 1'b1;
      cs_s         <= 1'b1;
      cs_prev      <= 1'b1;
      busy_prev    <= 1'b0;
      state_q      <= IDLE;
      ptr_q        <= 7'd0;
      wr_strobe    <= 1'b0;
      wr_addr      <= 7'd0;
      bus.tx_data  <= 8'h00;
      bus.tx_valid <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) reg_q[k] <= 8'h00;
    end else begin
      cs_meta      <= spi_cs;
      cs_s         <= cs_meta;
      cs_prev      <= cs_s;
      busy_prev    <= bus.spi_busy;
      state_q      <= state_nx;
      ptr_q        <= ptr_nx;
      wr_strobe    <= wr_en;
      bus.tx_valid <= byte_start;
      if (byte_start) bus.tx_data <= tx_nx;
      if (wr_en) begin
        wr_addr <= ptr_q;
        for (int k = 0; k < NUM_REGS; k++) begin
          if (7'(k) == ptr_q) reg_q[k] <= bus.rx_data;
        end
      end
    end
  end

  always_comb begin
    regs = '0;
    for (int k = 0; k < NUM_REGS; k++) regs[8*k +: 8] = reg_q[k];
  end

  assign frame_active = ~cs_s;
  assign state_dbg    = state_q;
  assign ptr_dbg      = ptr_q;

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- Sits directly downstream of SPI_Slave and consumes its received bytes (data_out/data_out_valid).
- Parses each chip-select frame as a command byte followed by data bytes, and maintains a bank of 8-bit registers.
- Feeds reply bytes back into SPI_Slave (data_in/data_in_valid) on each byte start, signalled by the rising edge of busy.
- Replaces the ad-hoc counter/LED glue in top; LEDs are driven from register 0.

Parameters:
- NUM_REGS, 16: number of 8-bit registers; legal range 1..128.
- STATUS_BYTE, 8'hA5: reply byte shifted out during the command byte.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- spi_cs  in  1  raw SPI chip select, active low, asynchronous to clk.
- rx_data  in  8  byte from SPI_Slave data_out.
- rx_valid  in  1  one-cycle pulse from SPI_Slave data_out_valid.
- spi_busy  in  1  SPI_Slave busy, already in the clk domain.
- tx_data  out  8  reply byte to SPI_Slave data_in.
- tx_valid  out  1  one-cycle pulse to SPI_Slave data_in_valid.
- regs  out  8*NUM_REGS  flattened register bank; reg k occupies bits [8k+7:8k].
- wr_strobe  out  1  one-cycle pulse when a register is written.
- wr_addr  out  7  address of the latest write; valid with wr_strobe.
- frame_active  out  1  synchronized chip select is asserted.

Behaviour:
- Reset (rst=0, asynchronous):
  - all regs = 0x00, tx_data = 0x00, tx_valid = 0, wr_strobe = 0, wr_addr = 0, frame_active = 0.
  - state = IDLE, pointer = 0, cs synchronizer flops = 1.
- CS handling: spi_cs passes through a 2-FF synchronizer (cs_s).
  - frame_active = ~cs_s.
  - A falling edge of cs_s moves the FSM to CMD.
  - A rising edge of cs_s moves any state to IDLE. This takes priority over all other events in the same cycle.
- Command byte format:
  - bit7 = 1 selects write, 0 selects read.
  - bits[6:0] = start address, loaded into the 7-bit pointer.
- FSM:
  - IDLE: rx_valid ignored; tx_valid still issued (see tx rules).
  - CMD: on rx_valid, pointer <= rx_data[6:0]; go to WRITE if bit7=1, else READ.
  - WRITE: each rx_valid writes reg[pointer] <= rx_data, then pointer increments.
  - READ: rx_valid bytes are discarded. Each tx byte issued returns reg[pointer], then pointer increments.
- Pointer arithmetic:
  - 7-bit, wraps 127 -> 0.
  - Writes to pointer >= NUM_REGS are dropped: no reg change and no wr_strobe; pointer still increments.
  - Reads at pointer >= NUM_REGS return 0x00.
- Write latency: reg value and wr_strobe/wr_addr are visible on the clk edge after the rx_valid cycle.
- tx rules:
  - A byte start is detected when spi_busy=1 and its previous-cycle sample=0.
  - tx_valid is registered: high for exactly one cycle, the cycle after detection. tx_data is updated on the same edge and holds until the next byte start.
  - tx_data by state at detection: IDLE or CMD -> STATUS_BYTE; WRITE -> 0x00; READ -> reg[pointer].
- Simultaneous events:
  - rx_valid and a byte start in the same cycle: rx_valid is processed first, and tx uses the post-rx state and pointer. Example: a command byte landing with a byte start yields reg[addr], not STATUS_BYTE.
  - A write to reg[pointer] and a read of that same register in the same cycle: the read returns the new value.
- Frame abort:
  - cs rising mid-frame leaves completed writes committed.
  - A partial byte is never seen; SPI_Slave does not emit it.
  - pointer is not cleared.
- rx_valid while spi_busy is low is legal and processed normally.

Test Plan:
- Reset, cs=1, pulse rst low -> regs all 0x00, tx_valid=0, frame_active=0; release rst -> frame_active stays 0.
- Write burst: cs low, bytes 0x82,0x11,0x22,0x33 -> reg2=0x11, reg3=0x22, reg4=0x33; wr_strobe pulses 3 times with wr_addr 2,3,4; replies STATUS 0xA5,0x00,0x00,0x00.
- Read burst after the write test: cs low, bytes 0x03,x,x -> tx_data sequence 0xA5,0x22,0x33; pointer ends at 5; regs unchanged.
- Wrap/out-of-range, NUM_REGS=16: write 0x8F,0xAA,0xBB -> reg15=0xAA, address 16 dropped (no strobe); read 0x7F,x,x -> replies 0xA5,0x00,0x00 (addresses 127 and 0).
- Abort: cs rises after the 0x80 command and one data byte 0x5A -> reg0=0x5A, FSM=IDLE; next rx_valid with cs high is ignored, regs unchanged.
- Same-cycle rx_valid and byte start in CMD with rx_data=0x01, reg1=0x77 -> tx_data=0x77, tx_valid one cycle later; async rst asserted mid-frame -> all outputs 0 immediately.
